dice_tid_dispatcher: RTL and testbench

Thread-ID dispatcher that drives the read and write sides of the per-port DICE register-file controller. It accepts a block of thread IDs and issues one TID per cycle to all enabled RF read ports. Each issued TID passes through a configurable-depth delay line that matches the CGRA datapath latency, and is then replayed as the write-back TID on the enabled RF write ports. It sits between the CGRA block scheduler and the RF controller, and reports completion once every issued thread has been written back.

---
 rtl/dice_tid_dispatcher.sv | 195 +++++++++++++++++++
 tb/tb_dice_tid_dispatcher.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dice_tid_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : dice_tid_dispatcher
//  Description : Issues one thread ID per non-stalled cycle to the enabled RF
//                read ports, delays each TID by the CGRA latency and replays it
//                as the write-back TID on the enabled RF write ports. Pulses
//                done once every issued thread has been written back.
//  Revision    : 1.0 - initial release
// ============================================================================
module dice_tid_dispatcher #(
    parameter int NUM_PORTS        = 16,
    parameter int NUM_TID          = 512,
    parameter int RF_ADDR_WIDTH    = $clog2(NUM_TID),
    parameter int MAX_CGRA_LATENCY = 32,
    localparam int LATW            = $clog2(MAX_CGRA_LATENCY + 1),
    localparam int CNTW            = $clog2(NUM_TID + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clr,
    input  logic                               start,
    output logic                               start_ready,
    input  logic [RF_ADDR_WIDTH-1:0]           tid_base,
    input  logic [CNTW-1:0]                    tid_count,
    input  logic [LATW-1:0]                    cgra_latency,
    input  logic [NUM_PORTS-1:0]               rd_port_mask,
    input  logic [NUM_PORTS-1:0]               wr_port_mask,
    input  logic                               stall,
    output logic [NUM_PORTS-1:0]               rd_en,
    output logic [NUM_PORTS*RF_ADDR_WIDTH-1:0] rd_tid,
    output logic [NUM_PORTS-1:0]               wr_en,
    output logic [NUM_PORTS*RF_ADDR_WIDTH-1:0] wr_tid,
    output logic                               busy,
    output logic                               done
);

    // Delay-line storage; at least one stage so the arrays stay legal.
    localparam int DEPTH = (MAX_CGRA_LATENCY > 0) ? MAX_CGRA_LATENCY : 1;
    localparam logic [LATW-1:0]          c_max_lat = LATW'(MAX_CGRA_LATENCY);
    localparam logic [RF_ADDR_WIDTH-1:0] c_tid_one = RF_ADDR_WIDTH'(1);

    // TID arithmetic relies on natural wrap of the address width.
    if ((NUM_TID < 1) || ((NUM_TID & (NUM_TID - 1)) != 0)) begin : g_chk_num_tid
        $fatal(1, "dice_tid_dispatcher: NUM_TID must be a power of two");
    end
    if (MAX_CGRA_LATENCY < 0) begin : g_chk_max_lat
        $fatal(1, "dice_tid_dispatcher: MAX_CGRA_LATENCY must be >= 0");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [CNTW-1:0]           r_count;
    logic [CNTW-1:0]           r_issued;
    logic [CNTW-1:0]           r_retired;
    logic [CNTW-1:0]           w_issued_next;
    logic [CNTW-1:0]           w_retired_next;
    logic [LATW-1:0]           r_lat;
    logic [LATW-1:0]           w_lat_sat;
    logic [NUM_PORTS-1:0]      r_rd_mask;
    logic [NUM_PORTS-1:0]      r_wr_mask;
    logic [RF_ADDR_WIDTH-1:0]  r_cur_tid;
    logic [DEPTH-1:0]          r_dl_vld;
    logic [RF_ADDR_WIDTH-1:0]  r_dl_tid [DEPTH];
    logic                      w_accept;
    logic                      w_in_flight;
    logic                      w_issue;
    logic                      w_retire;
    logic                      w_tap_vld;
    logic [RF_ADDR_WIDTH-1:0]  w_tap_tid;

    // A flush on the same edge wins over a new block request.
    assign w_accept       = start && (r_state == S_IDLE) && !clr;
    assign w_in_flight    = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign w_issue        = (r_state == S_ISSUE) && !stall;
    assign w_retire       = w_tap_vld && !stall;
    assign w_issued_next  = r_issued + CNTW'(w_issue);
    assign w_retired_next = r_retired + CNTW'(w_retire);
    // Latencies beyond the built delay line saturate at its full depth.
    assign w_lat_sat      = (cgra_latency > c_max_lat) ? c_max_lat : cgra_latency;

    // Select the write-back tap: L=0 bypasses straight from the issue register.
    always_comb begin
        w_tap_vld = (r_state == S_ISSUE);
        w_tap_tid = r_cur_tid;
        for (int i = 0; i < MAX_CGRA_LATENCY; i++) begin
            if (r_lat == LATW'(i + 1)) begin
                w_tap_vld = r_dl_vld[i] && w_in_flight;
                w_tap_tid = r_dl_tid[i];
            end
        end
    end

    // Next-state logic for the block sequencer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = (tid_count == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_issued_next == r_count) begin
                    w_state_next = (w_retired_next == r_count) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_retired_next == r_count) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State, sampled block configuration and issue/retire counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_issued  <= '0;
            r_retired <= '0;
            r_lat     <= '0;
            r_rd_mask <= '0;
            r_wr_mask <= '0;
            r_cur_tid <= '0;
        end else if (clr) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_issued  <= '0;
            r_retired <= '0;
            r_lat     <= '0;
            r_rd_mask <= '0;
            r_wr_mask <= '0;
            r_cur_tid <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_count   <= tid_count;
                r_issued  <= '0;
                r_retired <= '0;
                r_lat     <= w_lat_sat;
                r_rd_mask <= rd_port_mask;
                r_wr_mask <= wr_port_mask;
                r_cur_tid <= tid_base;
            end else begin
                if (w_issue) begin
                    r_issued  <= w_issued_next;
                    r_cur_tid <= r_cur_tid + c_tid_one;
                end
                if (w_retire) begin
                    r_retired <= w_retired_next;
                end
            end
        end
    end

    // Latency-matching shift register; frozen while stalled, emptied per block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dl_vld <= '0;
            for (int i = 0; i < DEPTH; i++) r_dl_tid[i] <= '0;
        end else if (clr) begin
            r_dl_vld <= '0;
            for (int i = 0; i < DEPTH; i++) r_dl_tid[i] <= '0;
        end else if (w_accept) begin
            r_dl_vld <= '0;
        end else if (!stall) begin
            r_dl_vld[0] <= w_issue;
            r_dl_tid[0] <= r_cur_tid;
            for (int i = 1; i < DEPTH; i++) begin
                r_dl_vld[i] <= r_dl_vld[i-1];
                r_dl_tid[i] <= r_dl_tid[i-1];
            end
        end
    end

    assign start_ready = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign rd_en       = r_rd_mask & {NUM_PORTS{w_issue}};
    assign wr_en       = r_wr_mask & {NUM_PORTS{w_retire}};
    assign rd_tid      = {NUM_PORTS{r_cur_tid}};
    assign wr_tid      = {NUM_PORTS{w_tap_tid}};

endmodule
`default_nettype wire

// File: tb/tb_dice_tid_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dice_tid_dispatcher
//  Description : Self-checking bench for dice_tid_dispatcher. A virtual-time
//                model predicts every output each cycle; directed blocks add
//                hand-computed literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dice_tid_dispatcher;

    localparam int NP   = 16;
    localparam int NT   = 512;
    localparam int AW   = 9;
    localparam int MAXL = 32;
    localparam int LW   = 6;
    localparam int CW   = 10;
    localparam int LOGN = 2048;

    logic            clk = 1'b0;
    logic            rst, clr, start, stall;
    logic            start_ready, busy, done;
    logic [AW-1:0]   tid_base;
    logic [CW-1:0]   tid_count;
    logic [LW-1:0]   cgra_latency;
    logic [NP-1:0]   rd_port_mask, wr_port_mask, rd_en, wr_en;
    logic [NP*AW-1:0] rd_tid, wr_tid;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Per-cycle observation logs, indexed by absolute cycle number.
    bit [NP-1:0] rd_en_log  [LOGN];
    bit [NP-1:0] wr_en_log  [LOGN];
    bit [AW-1:0] rd_tid_log [LOGN];
    bit [AW-1:0] wr_tid_log [LOGN];
    bit          done_log   [LOGN];
    bit          busy_log   [LOGN];
    bit          sr_log     [LOGN];

    dice_tid_dispatcher dut (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .start        (start),
        .start_ready  (start_ready),
        .tid_base     (tid_base),
        .tid_count    (tid_count),
        .cgra_latency (cgra_latency),
        .rd_port_mask (rd_port_mask),
        .wr_port_mask (wr_port_mask),
        .stall        (stall),
        .rd_en        (rd_en),
        .rd_tid       (rd_tid),
        .wr_en        (wr_en),
        .wr_tid       (wr_tid),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [NP*AW-1:0] act,
                         input logic [NP*AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: in a block, the thread at index i is read after i non-stalled
    // cycles and written back after i+L non-stalled cycles; done follows the
    // (N+L)-th non-stalled cycle.
    int          m_phase;   // 0 idle, 1 active, 2 done
    int          m_base, m_n, m_l, m_adv;
    bit          m_zero;
    logic [NP-1:0] m_rdm, m_wrm;

    initial begin
        logic [NP-1:0] e_rd_en, e_wr_en;
        logic [AW-1:0] e_rd_tid, e_wr_tid;
        bit            rd_chk, wr_chk;
        m_phase = 0; m_zero = 1; m_adv = 0; m_n = 0; m_l = 0; m_base = 0;
        m_rdm = '0; m_wrm = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_phase = 0;
                m_zero  = 1;
            end
            e_rd_en = '0; e_wr_en = '0; e_rd_tid = '0; e_wr_tid = '0;
            rd_chk = 0; wr_chk = 0;
            if (m_phase == 1) begin
                if (m_adv < m_n) begin
                    rd_chk   = 1;
                    e_rd_tid = AW'((m_base + m_adv) % NT);
                    if (!stall) e_rd_en = m_rdm;
                end
                if (m_adv >= m_l && (m_adv - m_l) < m_n) begin
                    wr_chk   = 1;
                    e_wr_tid = AW'((m_base + m_adv - m_l) % NT);
                    if (!stall) e_wr_en = m_wrm;
                end
            end else if (m_phase == 0 && m_zero) begin
                rd_chk = 1;
                wr_chk = 1;
            end
            check("busy",        busy,        (m_phase != 0));
            check("done",        done,        (m_phase == 2));
            check("start_ready", start_ready, (m_phase == 0));
            check("rd_en",       rd_en,       e_rd_en);
            check("wr_en",       wr_en,       e_wr_en);
            if (rd_chk) check("rd_tid", rd_tid, {NP{e_rd_tid}});
            if (wr_chk) check("wr_tid", wr_tid, {NP{e_wr_tid}});

            if (cyc < LOGN) begin
                rd_en_log[cyc]  = rd_en;
                wr_en_log[cyc]  = wr_en;
                rd_tid_log[cyc] = rd_tid[AW-1:0];
                wr_tid_log[cyc] = wr_tid[AW-1:0];
                done_log[cyc]   = done;
                busy_log[cyc]   = busy;
                sr_log[cyc]     = start_ready;
            end

            if (rst) begin
                m_phase = 0;
            end else if (clr) begin
                m_phase = 0;
                m_zero  = 1;
            end else begin
                case (m_phase)
                    0: if (start) begin
                        m_base  = int'(tid_base);
                        m_n     = int'(tid_count);
                        m_l     = (int'(cgra_latency) > MAXL) ? MAXL : int'(cgra_latency);
                        m_rdm   = rd_port_mask;
                        m_wrm   = wr_port_mask;
                        m_adv   = 0;
                        m_zero  = 0;
                        m_phase = (m_n == 0) ? 2 : 1;
                    end
                    1: if (!stall) begin
                        m_adv++;
                        if (m_adv == m_n + m_l) m_phase = 2;
                    end
                    default: m_phase = 0;
                endcase
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a block at relative cycle 0, then drive stall/clr/extra start by
    // relative cycle number; returns the accept cycle.
    task automatic run(input int base, input int cnt, input int lat,
                       input logic [NP-1:0] rdm, input logic [NP-1:0] wrm,
                       input int st_lo, input int st_hi, input int clr_at,
                       input int restart_at, input int ncyc, output int t0);
        step();
        tid_base     = AW'(base);
        tid_count    = CW'(cnt);
        cgra_latency = LW'(lat);
        rd_port_mask = rdm;
        wr_port_mask = wrm;
        start = 1'b1; stall = 1'b0; clr = 1'b0;
        t0 = cyc;
        for (int r = 1; r <= ncyc; r++) begin
            step();
            start = (r == restart_at);
            if (r == restart_at) begin
                tid_count = CW'(5);
                tid_base  = AW'(77);
            end
            stall = (r >= st_lo && r <= st_hi);
            clr   = (r == clr_at);
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int nd;
        rst = 1'b1; clr = 1'b0; start = 1'b0; stall = 1'b0;
        tid_base = '0; tid_count = '0; cgra_latency = '0;
        rd_port_mask = '0; wr_port_mask = '0;
        step();
        step();
        check("rst_start_ready", start_ready, 1'b1);
        check("rst_busy",        busy,        1'b0);
        check("rst_done",        done,        1'b0);
        check("rst_rd_en",       rd_en,       '0);
        check("rst_wr_en",       wr_en,       '0);
        rst = 1'b0;
        step();

        // Block 1: base 0, 8 threads, L=3.
        run(0, 8, 3, 16'hFFFF, 16'hFFFF, -1, -1, -1, -1, 14, t0);
        check("b1_rd_tid_c1",  rd_tid_log[t0+1],  9'd0);
        check("b1_rd_tid_c8",  rd_tid_log[t0+8],  9'd7);
        check("b1_wr_en_c4",   wr_en_log[t0+4],   16'hFFFF);
        check("b1_wr_en_c3",   wr_en_log[t0+3],   16'h0000);
        check("b1_wr_tid_c4",  wr_tid_log[t0+4],  9'd0);
        check("b1_wr_tid_c11", wr_tid_log[t0+11], 9'd7);
        check("b1_done_c12",   done_log[t0+12],   1'b1);
        check("b1_done_c11",   done_log[t0+11],   1'b0);
        check("b1_ready_c13",  sr_log[t0+13],     1'b1);

        // Block 2: TID wrap, L=0 bypass, distinct masks.
        run(510, 4, 0, 16'h0003, 16'h8000, -1, -1, -1, -1, 7, t0);
        check("b2_rd_en_c1",   rd_en_log[t0+1],  16'h0003);
        check("b2_rd_tid_c1",  rd_tid_log[t0+1], 9'd510);
        check("b2_rd_tid_c2",  rd_tid_log[t0+2], 9'd511);
        check("b2_rd_tid_c3",  rd_tid_log[t0+3], 9'd0);
        check("b2_wr_en_c3",   wr_en_log[t0+3],  16'h8000);
        check("b2_wr_tid_c4",  wr_tid_log[t0+4], 9'd1);
        check("b2_done_c5",    done_log[t0+5],   1'b1);

        // Block 3: stall during cycles 3 and 4.
        run(0, 6, 2, 16'hFFFF, 16'hFFFF, 3, 4, -1, -1, 13, t0);
        check("b3_rd_en_c3",   rd_en_log[t0+3],  16'h0000);
        check("b3_wr_en_c4",   wr_en_log[t0+4],  16'h0000);
        check("b3_rd_tid_c5",  rd_tid_log[t0+5], 9'd2);
        check("b3_rd_en_c5",   rd_en_log[t0+5],  16'hFFFF);
        check("b3_done_c11",   done_log[t0+11],  1'b1);
        check("b3_done_c10",   done_log[t0+10],  1'b0);

        // Block 4: zero threads, plus a start pulse while busy.
        run(0, 0, 4, 16'hFFFF, 16'hFFFF, -1, -1, -1, 1, 6, t0);
        check("b4_done_c1",    done_log[t0+1],   1'b1);
        check("b4_rd_en_c1",   rd_en_log[t0+1],  16'h0000);
        check("b4_wr_en_c1",   wr_en_log[t0+1],  16'h0000);
        check("b4_ready_c2",   sr_log[t0+2],     1'b1);
        check("b4_busy_c3",    busy_log[t0+3],   1'b0);

        // Block 5: flush mid-issue, then a fresh block right after.
        run(0, 16, 5, 16'hFFFF, 16'hFFFF, -1, -1, 7, -1, 8, t0);
        nd = 0;
        for (int k = 1; k <= 8; k++) nd += int'(done_log[t0+k]);
        check("b5_no_done",    nd,               0);
        check("b5_busy_c8",    busy_log[t0+8],   1'b0);
        check("b5_ready_c8",   sr_log[t0+8],     1'b1);
        check("b5_wr_en_c8",   wr_en_log[t0+8],  16'h0000);
        check("b5_wr_tid_c8",  wr_tid_log[t0+8], 9'd0);
        run(100, 3, 1, 16'h00F0, 16'h0F00, -1, -1, -1, -1, 6, t0);
        check("b6_rd_tid_c3",  rd_tid_log[t0+3], 9'd102);
        check("b6_wr_tid_c2",  wr_tid_log[t0+2], 9'd100);
        check("b6_wr_en_c2",   wr_en_log[t0+2],  16'h0F00);
        check("b6_done_c5",    done_log[t0+5],   1'b1);

        // Block 7: asynchronous reset while draining.
        run(20, 16, 5, 16'hFFFF, 16'hFFFF, -1, -1, -1, -1, 18, t0);
        step();
        #2;
        rst = 1'b1;
        #1;
        check("arst_rd_en",       rd_en,       '0);
        check("arst_wr_en",       wr_en,       '0);
        check("arst_rd_tid",      rd_tid,      '0);
        check("arst_wr_tid",      wr_tid,      '0);
        check("arst_busy",        busy,        1'b0);
        check("arst_done",        done,        1'b0);
        check("arst_start_ready", start_ready, 1'b1);
        step();
        rst = 1'b0;
        step();
        run(7, 2, 1, 16'h0001, 16'h0002, -1, -1, -1, -1, 6, t0);
        check("b8_done_c4",    done_log[t0+4],   1'b1);
        check("b8_wr_tid_c3",  wr_tid_log[t0+3], 9'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
